// File: rtl/alu_issue_buf_if.sv
// alu_issue_buf_if: issue-side, ALU-side, flush and writeback signals of the ALU issue buffer
interface alu_issue_buf_if #(parameter int DATA_W = 18);
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic [2:0]        in_ctrl, in_rd, in_rs1, in_rs2;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_a, out_b;
  logic [2:0]        out_ctrl, out_rd;
  logic              flush, wb_valid;
  logic [2:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  modport slave (
    input  in_valid, in_a, in_b, in_ctrl, in_rd, in_rs1, in_rs2, out_ready, flush, wb_valid, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_ctrl, out_rd
  );
  modport master (
    output in_valid, in_a, in_b, in_ctrl, in_rd, in_rs1, in_rs2, out_ready, flush, wb_valid, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_ctrl, out_rd
  );
endinterface

// File: rtl/alu_issue_buf.sv
// alu_issue_buf: 2-entry in-order ALU issue FIFO; define ALU_ISSUE_FWD_EN for writeback forwarding
module alu_issue_buf #(parameter int DATA_W = 18) (
  input logic clk,
  input logic rst_n,
  alu_issue_buf_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] a, b;
    logic [2:0]        ctrl, rd;
`ifdef ALU_ISSUE_FWD_EN
    logic [2:0]        rs1, rs2;
`endif
  } entry_t;
  entry_t head, tail, head_f, tail_f, in_e;
  logic [1:0] count;
  logic push, pop;
  assign push = bus.in_valid && count != 2'd2;
  assign pop = bus.out_ready && count != 2'd0;
`ifdef ALU_ISSUE_FWD_EN
  logic hit;
  assign hit = bus.wb_valid && bus.wb_rd != 3'd0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.in_rs1, bus.in_rs2, bus.wb_valid, bus.wb_rd, bus.wb_data};
`endif
  always_comb begin
    in_e.a = bus.in_a;
    in_e.b = bus.in_b;
    in_e.ctrl = bus.in_ctrl;
    in_e.rd = bus.in_rd;
    head_f = head;
    tail_f = tail;
`ifdef ALU_ISSUE_FWD_EN
    in_e.rs1 = bus.in_rs1;
    in_e.rs2 = bus.in_rs2;
    in_e.a = (hit && bus.wb_rd == bus.in_rs1) ? bus.wb_data : bus.in_a;
    in_e.b = (hit && bus.wb_rd == bus.in_rs2) ? bus.wb_data : bus.in_b;
    head_f.a = (hit && bus.wb_rd == head.rs1) ? bus.wb_data : head.a;
    head_f.b = (hit && bus.wb_rd == head.rs2) ? bus.wb_data : head.b;
    tail_f.a = (hit && bus.wb_rd == tail.rs1) ? bus.wb_data : tail.a;
    tail_f.b = (hit && bus.wb_rd == tail.rs2) ? bus.wb_data : tail.b;
`endif
  end
  // head takes the new entry when the FIFO is (or becomes) otherwise empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (bus.flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      head <= (push && (count == 2'd0 || (pop && count == 2'd1))) ? in_e : (pop && count == 2'd2) ? tail_f : head_f;
      tail <= (push && !pop && count == 2'd1) ? in_e : tail_f;
    end
  end
  assign bus.in_ready = count != 2'd2;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_a = head.a;
  assign bus.out_b = head.b;
  assign bus.out_ctrl = head.ctrl;
  assign bus.out_rd = head.rd;
endmodule

// File: doc/alu_issue_buf.md
ALU_ISSUE_BUF -- requirements
Module: alu_issue_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 18, operand width in bits.
REQ-002 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid input 1: upstream (decode) offers an operation.
REQ-005 SHALL have port in_ready output 1: buffer can accept this cycle.
REQ-006 SHALL have ports in_a, in_b input DATA_W: operands.
REQ-007 SHALL have port in_ctrl input 3: ALU op code (000 ADD … 101 SRA).
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2 input 3: destination and source register indices.
REQ-009 SHALL have port out_valid output 1: head entry is presented to the ALU.
REQ-010 SHALL have port out_ready input 1: downstream consumes the head entry.
REQ-011 SHALL have ports out_a, out_b output DATA_W, out_ctrl output 3 and out_rd output 3: head-entry fields, wired to the ALU A, B and ALUctrl inputs.
REQ-012 SHALL have port flush input 1: discard all held entries.
REQ-013 SHALL have ports wb_valid input 1, wb_rd input 3 and wb_data input DATA_W: writeback result bus.

Function
REQ-014 SHALL be a 2-entry in-order FIFO (head, tail) with a registered occupancy count of 0..2.
REQ-015 SHALL accept on in_valid && in_ready and pop on out_valid && out_ready, both at the clock edge.
REQ-016 SHALL drive in_ready = (count != 2) and out_valid = (count != 0), decoded from registered state only, with no combinational path from out_ready to in_ready.
REQ-017 SHALL drive out_* directly from head-entry registers; data accepted in cycle N appears on out_* in cycle N+1 at the earliest, giving 1-cycle latency.
REQ-018 SHALL handle push and pop in the same cycle:
- count 1: count stays 1 and the new entry becomes head.
- count 2: push is impossible because in_ready is low.
REQ-019 SHALL, on pop at count 2, move tail to head and set count to 1.
REQ-020 SHALL, on flush, set count to 0 at the next edge; flush overrides a simultaneous push and pop, and the offered entry is dropped.
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 SHALL pass op codes 110 and 111 through unmodified, with no error flag.
REQ-023 SHALL leave out_* values unspecified while out_valid is 0; the bench SHALL NOT check them.

Reset
REQ-024 SHALL, on rst_n low, immediately set count to 0, in_ready to 1, out_valid to 0, and out_a, out_b, out_ctrl and out_rd to 0, independent of clk.
REQ-025 SHALL discard any in-flight entry when reset is asserted mid-operation; the first accept after release SHALL be treated as entry 0.

Configuration
REQ-026 SHALL use macro ALU_ISSUE_FWD_EN to enable writeback forwarding.
REQ-027 SHALL, with ALU_ISSUE_FWD_EN defined and wb_valid && wb_rd != 0:
- on accept, capture wb_data instead of in_a when wb_rd == in_rs1, and instead of in_b when wb_rd == in_rs2;
- replace held head or tail operands whose stored rs1 or rs2 matches wb_rd with wb_data at the edge.
REQ-028 SHALL, with ALU_ISSUE_FWD_EN undefined, ignore in_rs1, in_rs2 and all wb_* ports, store no rs fields, and capture operands verbatim.

Verification
REQ-029 SHALL cover back-to-back flow: out_ready=1, push A=5,B=3,ctrl=000 then A=7,B=7,ctrl=001 -> out_* shows each 1 cycle later and in_ready stays 1.
REQ-030 SHALL cover backpressure: out_ready=0, push 3 ops -> in_ready drops after 2nd accept, 3rd is held upstream, then out_ready=1 -> ops exit in order 1, 2, 3.
REQ-031 SHALL cover flush: count=2 with in_valid=1 and flush=1 -> next cycle out_valid=0, count=0, and the new op is not captured.
REQ-032 SHALL cover async reset: rst_n low mid-cycle with count=2 -> out_valid=0 and in_ready=1 before the next clk edge.
REQ-033 SHALL cover accept forwarding (FWD_EN): accept in_rs1=2, in_a=0x00001 with wb_valid=1, wb_rd=2, wb_data=0x3FFFF -> out_a=0x3FFFF.
REQ-034 SHALL cover held forwarding and r0 (FWD_EN): stalled head with rs2=4, then wb_rd=4, wb_data=0x00010 -> out_b=0x00010 next cycle; the same with wb_rd=0 -> out_b unchanged.
